// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with the HI/LO register pair.
// Latency: WIDTH+2 cycles from acceptance to HI/LO update; MTHI/MTLO take effect next edge.
// Backpressure: stall = busy & (start | rd_req); start is only accepted while idle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             rd_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] rs_raw;
    logic             is_div;
    logic             sign_a;
    logic             sign_b;
    logic             div_zero;

    logic             op_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign stall = busy & (start | rd_req);

    always_comb begin
        op_signed = ~op[0];
        rs_neg    = op_signed & rs_val[WIDTH-1];
        rt_neg    = op_signed & rt_val[WIDTH-1];
        rs_mag    = rs_neg ? -rs_val : rs_val;
        rt_mag    = rt_neg ? -rt_val : rt_val;

        // Multiply: acc_lo holds the unconsumed multiplier bits, product grows in from the top.
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_a} : '0);

        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, mag_a};
        div_diff  = div_shift[WIDTH-1:0] - mag_a;

        prod_fix  = (sign_a ^ sign_b) ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
        rem_fix   = sign_a ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            mag_a    <= '0;
            rs_raw   <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                acc_hi   <= '0;
                                acc_lo   <= op[1] ? rs_mag : rt_mag;
                                mag_a    <= op[1] ? rt_mag : rs_mag;
                                sign_a   <= rs_neg;
                                sign_b   <= rt_neg;
                                is_div   <= op[1];
                                div_zero <= (rt_val == '0);
                                rs_raw   <= rs_val;
                                cnt      <= '0;
                                busy     <= 1'b1;
                                state    <= CALC;
                            end
                            3'd4:    hi <= rs_val;
                            3'd5:    lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= SIGN;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                SIGN: begin
                    if (is_div) begin
                        // Divide by zero bypasses fix-up and returns the dividend untouched.
                        if (div_zero) begin
                            hi <= rs_raw;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected HI/LO queued at issue, compared when done pulses.
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rd_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .rd_req (rd_req),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .stall  (stall),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the architectural rules.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          q;
        longint          m;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned um;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = '0;
        case (o)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) r = {a, 32'hFFFFFFFF};
                else begin
                    uq = ua / ub;
                    um = ua % ub;
                    r  = {um[31:0], uq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result_hilo", {hi, lo}, mon_exp);
            end
        end
    end

    // Issues one mul/div and checks per-cycle timing; optional rd_req hazard
    // from cycle rd_from and an MTLO held from cycle mt_from.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int rd_from, input int mt_from, input logic [31:0] mt_val);
        logic [63:0] e;
        logic        exp_stall;
        e = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; rs_val = $urandom(); rt_val = $urandom();
        for (int k = 1; k <= WIDTH + 2; k++) begin
            @(negedge clk);
            rd_req = (rd_from > 0) && (k >= rd_from);
            if (mt_from > 0 && k >= mt_from) begin
                start = 1'b1; op = 3'd5; rs_val = mt_val;
            end
            #1;
            exp_stall = (k <= WIDTH + 1) && (rd_req || start);
            chk("busy", 64'(busy), 64'(k <= WIDTH + 1));
            chk("stall", 64'(stall), 64'(exp_stall));
            chk("done", 64'(done), 64'(k == WIDTH + 2));
        end
        if (rd_from > 0) chk("hilo_visible_at_done", {hi, lo}, e);
        if (mt_from > 0) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("mtlo_after_busy", {hi, lo}, {e[63:32], mt_val});
            chk("busy_after_mtlo", 64'(busy), 64'd0);
        end
        rd_req = 1'b0;
        start  = 1'b0;
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; rd_req = 1'b0; op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rd_req = 1'b1;
        #1;
        chk("reset_hilo", {hi, lo}, 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_stall", 64'(stall), 64'd0);
        rd_req = 1'b0;
        rst    = 1'b0;

        run_op(3'd1, 32'd7, 32'd6, 0, 0, 0);
        run_op(3'd0, 32'hFFFFFFFD, 32'd5, 0, 0, 0);
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 0, 0, 0);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
        run_op(3'd3, 32'd100, 32'd0, 0, 0, 0);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
        run_op(3'd2, 32'hFFFFFF00, 32'd0, 0, 0, 0);
        run_op(3'd3, 32'd1000, 32'd7, 5, 0, 0);
        run_op(3'd3, 32'd12345, 32'd17, 0, 3, 32'h1234);

        // Reset mid-CALC: aborts with no done.
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'hFFFFFFF9; rt_val = 32'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        rst = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("no_done_after_abort", 64'(done_seen), 64'd0);
        run_op(3'd1, 32'd3, 32'd3, 0, 0, 0);

        // MTHI / MTLO / ignored ops in IDLE.
        @(negedge clk);
        start = 1'b1; op = 3'd4; rs_val = 32'hDEAD;
        @(negedge clk);
        chk("mthi", {hi, lo}, {32'hDEAD, 32'd9});
        op = 3'd5; rs_val = 32'hBEEF;
        @(negedge clk);
        chk("mtlo", {hi, lo}, {32'hDEAD, 32'hBEEF});
        chk("mt_busy", 64'(busy), 64'd0);
        chk("mt_done", 64'(done), 64'd0);
        op = 3'd6; rs_val = 32'h5555; rt_val = 32'h7777;
        @(negedge clk);
        chk("op6_ignored", {hi, lo}, {32'hDEAD, 32'hBEEF});
        chk("op6_busy", 64'(busy), 64'd0);
        op = 3'd7;
        @(negedge clk);
        chk("op7_ignored", {hi, lo}, {32'hDEAD, 32'hBEEF});
        start = 1'b0;

        repeat (20) begin
            logic [2:0]  o;
            logic [31:0] a;
            logic [31:0] b;
            o = 3'($urandom_range(0, 3));
            a = pick();
            b = pick();
            run_op(o, a, b, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
